// File: rtl/pad_frame_pkg.sv
// Shared pad-frame definitions: per-pad config bit positions, config type and a width helper.
package pad_frame_pkg;

  localparam int PADCFG_PULL = 0;
  localparam int PADCFG_FILT = 1;
  localparam int PADCFG_HOLD = 2;

  localparam int NBIT_PADCFG_DEFAULT = 6;

  typedef logic [NBIT_PADCFG_DEFAULT-1:0] pad_cfg_t;

  // Glitch counter width; sized so FILT_LEN-1 always fits and the counter never wraps.
  function automatic int filt_cnt_width(input int filt_len);
    return (filt_len < 1) ? 1 : $clog2(filt_len + 1);
  endfunction

endpackage

// File: rtl/pad_functional_pd.sv
// Behavioural generic bidirectional pad with pull-down control (PEN active-low).
module pad_functional_pd (
  input  logic OEN,
  input  logic I,
  output logic O,
  input  logic PEN,
  inout  wire  PAD
);

  // The pull-down only exists in the technology cell; it has no digital behaviour here.
  logic unused_pen;
  assign unused_pen = PEN;

  assign PAD = OEN ? 1'bz : I;
  assign O   = PAD;

endmodule

// File: rtl/pad_in_filter.sv
// One pad input: 2-flop synchroniser, optional glitch filter and rise/fall event pulses.
module pad_in_filter
  import pad_frame_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pad_i,
  input  logic filt_en_i,
  output logic data_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = filt_cnt_width(FILT_LEN);

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic          filt_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (!filt_en_i) begin
      filt_d = sync2_q;
    end else if (sync2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(FILT_LEN - 1)) begin
      filt_d = sync2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      filt_q     <= 1'b0;
      filt_dly_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= pad_i;
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      cnt_q      <= cnt_d;
    end
  end

  assign data_o = filt_q;
  assign rise_o = filt_q & ~filt_dly_q;
  assign fall_o = ~filt_q & filt_dly_q;

endmodule

// File: rtl/pad_frame_filt.sv
// Parametrised pad frame: N_IO bidirectional pads with output hold and conditioned inputs.
module pad_frame_filt
  import pad_frame_pkg::*;
#(
  parameter int N_IO        = 48,
  parameter int NBIT_PADCFG = 6,
  parameter int FILT_LEN    = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_IO*NBIT_PADCFG-1:0] pad_cfg_i,
  input  logic [N_IO-1:0]             io_out_i,
  input  logic [N_IO-1:0]             io_oe_i,
  output logic [N_IO-1:0]             io_in_o,
  output logic [N_IO-1:0]             io_rise_o,
  output logic [N_IO-1:0]             io_fall_o,
  inout  wire  [N_IO-1:0]             io
);

  for (genvar gi = 0; gi < N_IO; gi++) begin : g_pad
    logic [NBIT_PADCFG-1:0] cfg;
    logic                   hold;
    logic                   out_q, out_d;
    logic                   oe_q, oe_d;
    logic                   out_eff, oe_eff;
    logic                   pad_in;

    assign cfg  = pad_cfg_i[gi*NBIT_PADCFG +: NBIT_PADCFG];
    assign hold = cfg[PADCFG_HOLD];

    always_comb begin
      out_d = out_q;
      oe_d  = oe_q;
      if (!hold) begin
        out_d = io_out_i[gi];
        oe_d  = io_oe_i[gi];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        out_q <= 1'b0;
        oe_q  <= 1'b0;
      end else begin
        out_q <= out_d;
        oe_q  <= oe_d;
      end
    end

    // Pass-through is combinational, so the enable is gated to keep pins tristated in reset.
    assign out_eff = hold ? out_q : io_out_i[gi];
    assign oe_eff  = rst_ni & (hold ? oe_q : io_oe_i[gi]);

    pad_functional_pd u_pad (
      .OEN (~oe_eff),
      .I   (out_eff),
      .O   (pad_in),
      .PEN (~cfg[PADCFG_PULL]),
      .PAD (io[gi])
    );

    pad_in_filter #(
      .FILT_LEN (FILT_LEN)
    ) u_filt (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .pad_i     (pad_in),
      .filt_en_i (cfg[PADCFG_FILT]),
      .data_o    (io_in_o[gi]),
      .rise_o    (io_rise_o[gi]),
      .fall_o    (io_fall_o[gi])
    );

    if (NBIT_PADCFG > 3) begin : g_spare
      logic [NBIT_PADCFG-4:0] unused_cfg;
      assign unused_cfg = cfg[NBIT_PADCFG-1:3];
    end
  end

endmodule

// File: tb/tb_pad_frame_filt.sv
// Self-checking bench for pad_frame_filt: directed scenarios plus randomized pin toggling vs a reference model.
module tb_pad_frame_filt;
  import pad_frame_pkg::*;

  localparam int N_IO = 8;
  localparam int NB   = 3;
  localparam int FL   = 4;

  logic                clk     = 1'b0;
  logic                rst_ni  = 1'b0;
  logic [N_IO*NB-1:0]  pad_cfg = '0;
  logic [N_IO-1:0]     io_out  = '0;
  logic [N_IO-1:0]     io_oe   = '0;
  logic [N_IO-1:0]     io_in, io_rise, io_fall;
  wire  [N_IO-1:0]     io;
  logic [N_IO-1:0]     tb_en   = '0;
  logic [N_IO-1:0]     tb_val  = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N_IO; gi++) begin : g_drv
    assign io[gi] = tb_en[gi] ? tb_val[gi] : 1'bz;
  end

  pad_frame_filt #(
    .N_IO        (N_IO),
    .NBIT_PADCFG (NB),
    .FILT_LEN    (FL)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .pad_cfg_i (pad_cfg),
    .io_out_i  (io_out),
    .io_oe_i   (io_oe),
    .io_in_o   (io_in),
    .io_rise_o (io_rise),
    .io_fall_o (io_fall),
    .io        (io)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N_IO-1:0] pin_vec();
    logic [N_IO-1:0] v;
    for (int k = 0; k < N_IO; k++) v[k] = (io[k] === 1'b1);
    return v;
  endfunction

  // Reference: io_in follows the pin seen two samples ago; with the filter on it flips only
  // once the last FL synchronised samples all disagree with the current value.
  function automatic logic model_next(input logic [31:0] h, input logic cur, input logic filt_en);
    logic flip;
    if (!filt_en) return h[2];
    flip = 1'b1;
    for (int j = 0; j < FL; j++) if (h[2+j] == cur) flip = 1'b0;
    return flip ? ~cur : cur;
  endfunction

  logic [31:0]     hist [N_IO];
  logic [N_IO-1:0] m_in   = '0;
  logic [N_IO-1:0] m_prev = '0;
  int              m_chg  [N_IO];
  int              dut_ev [N_IO];

  initial begin
    for (int k = 0; k < N_IO; k++) begin
      hist[k]   = '0;
      m_chg[k]  = 0;
      dut_ev[k] = 0;
    end
  end

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < N_IO; k++) hist[k] <= '0;
      m_in   <= '0;
      m_prev <= '0;
    end else begin
      m_prev <= m_in;
      for (int k = 0; k < N_IO; k++) begin
        hist[k]  <= {hist[k][30:0], (io[k] === 1'b1)};
        m_in[k]  <= model_next({hist[k][30:0], (io[k] === 1'b1)}, m_in[k], pad_cfg[k*NB+PADCFG_FILT]);
        if (model_next({hist[k][30:0], (io[k] === 1'b1)}, m_in[k], pad_cfg[k*NB+PADCFG_FILT]) != m_in[k])
          m_chg[k] <= m_chg[k] + 1;
      end
    end
  end

  // Continuous comparison against the model, 2 ns after each active edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst_ni) begin
        check("io_in", 32'(io_in), 32'(m_in));
        check("io_rise", 32'(io_rise), 32'(m_in & ~m_prev));
        check("io_fall", 32'(io_fall), 32'(~m_in & m_prev));
        check("rise_and_fall", 32'(io_rise & io_fall), 32'(0));
        for (int k = 0; k < N_IO; k++) dut_ev[k] += int'(io_rise[k] | io_fall[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [1:0] r;

    // 1: reset with every pad requesting drive -> pins tristated, outputs quiet
    io_oe  = '1;
    io_out = '1;
    repeat (3) tick();
    check("rst_pins_z", 32'(pin_vec()), 32'(0));
    check("rst_io_in", 32'(io_in), 32'(0));
    check("rst_events", 32'(io_rise | io_fall), 32'(0));
    $display("test1 reset: pins=%0h io_in=%0h", pin_vec(), io_in);
    @(negedge clk);
    io_oe  = '0;
    io_out = '0;
    tb_en  = '1;
    tb_val = '0;
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (3) tick();

    // 2: filter off, pad 5 rises -> io_in on the 3rd edge, one-cycle rise
    @(negedge clk);
    tb_val[5] = 1'b1;
    tick(); check("t2_e1", 32'(io_in[5]), 32'(0));
    tick(); check("t2_e2", 32'(io_in[5]), 32'(0));
    tick(); check("t2_e3", 32'(io_in[5]), 32'(1));
    check("t2_rise_e3", 32'(io_rise[5]), 32'(1));
    tick(); check("t2_rise_e4", 32'(io_rise[5]), 32'(0));
    $display("test2 filter off: io_in[5]=%b", io_in[5]);

    // 3: filter on pad 7: 3-cycle glitch rejected, 6-cycle level accepted on 6th edge
    @(negedge clk);
    pad_cfg[7*NB+PADCFG_FILT] = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    tb_val[7] = 1'b1;
    repeat (3) @(negedge clk);
    tb_val[7] = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      check("t3_glitch", 32'({io_in[7], io_rise[7]}), 32'(0));
    end
    @(negedge clk);
    tb_val[7] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check($sformatf("t3_level_e%0d", e), 32'(io_in[7]), 32'(e == 6));
    end
    check("t3_rise", 32'(io_rise[7]), 32'(1));
    tick(); check("t3_rise_after", 32'(io_rise[7]), 32'(0));
    $display("test3 glitch filter: io_in[7]=%b", io_in[7]);

    // 4: output hold on pad 3
    @(negedge clk);
    tb_en[3]  = 1'b0;
    io_out[3] = 1'b1;
    io_oe[3]  = 1'b1;
    tick(); check("t4_drive", 32'(pin_vec() >> 3 & 1), 32'(1));
    @(negedge clk);
    pad_cfg[3*NB+PADCFG_HOLD] = 1'b1;
    tick();
    @(negedge clk);
    io_out[3] = 1'b0;
    io_oe[3]  = 1'b0;
    tick(); tick();
    check("t4_held", 32'(pin_vec() >> 3 & 1), 32'(1));
    @(negedge clk);
    pad_cfg[3*NB+PADCFG_HOLD] = 1'b0;
    #1;
    check("t4_release_z", 32'(pin_vec() >> 3 & 1), 32'(0));
    tb_en[3]  = 1'b1;
    tb_val[3] = 1'b0;
    $display("test4 output hold: pin3 released");
    repeat (4) tick();

    // 5: reset mid-count on filtered pad 2, then exact latency after release
    @(negedge clk);
    pad_cfg[2*NB+PADCFG_FILT] = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    tb_val[2] = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    check("t5_rst_io_in", 32'(io_in), 32'(0));
    check("t5_rst_events", 32'(io_rise | io_fall), 32'(0));
    repeat (2) tick();
    check("t5_rst_hold", 32'(io_in), 32'(0));
    @(negedge clk);
    rst_ni = 1'b1;
    for (int e = 1; e <= 2 + FL; e++) begin
      tick();
      check($sformatf("t5_e%0d", e), 32'({io_in[2], io_rise[2]}), 32'((e == 2 + FL) ? 2'b11 : 2'b00));
    end
    tick(); check("t5_one_pulse", 32'({io_in[2], io_rise[2]}), 32'(2'b10));
    $display("test5 reset mid-count: io_in[2]=%b", io_in[2]);

    // 6: randomized toggling, config changed only while pins are stable
    for (int ph = 0; ph < 6; ph++) begin
      @(negedge clk);
      repeat (10) tick();
      @(negedge clk);
      for (int k = 0; k < N_IO; k++) begin
        r = 2'($urandom_range(0, 3));
        pad_cfg[k*NB +: NB] = {1'b0, r};
      end
      for (int c = 0; c < 80; c++) begin
        @(negedge clk);
        for (int k = 0; k < N_IO; k++)
          if ($urandom_range(0, 2) == 0) tb_val[k] = ~tb_val[k];
      end
      $display("test6 phase %0d: cfg=%0h pins=%0h io_in=%0h", ph, pad_cfg, tb_val, io_in);
    end
    @(negedge clk);
    repeat (10) tick();
    for (int k = 0; k < N_IO; k++)
      check($sformatf("evt_count_pad%0d", k), 32'(dut_ev[k]), 32'(m_chg[k]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
